// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared opcode constants, NOP word and fetch FSM encoding
//
// Purpose : constants and types shared by instruction_fetch, pc_next_sel and Control_Unit.
// Ports   : none (package).

package instruction_fetch_pkg;

  // instruction[6:2] major opcodes that stop the fetch unit
  localparam logic [4:0]  OPC_FENCE  = 5'b00011;  // FENCE / FENCE.TSO / PAUSE
  localparam logic [4:0]  OPC_SYSTEM = 5'b11100;  // ECALL / EBREAK

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Only 32-bit encodings (low bits 11) are considered halt opcodes.
  function automatic logic is_halt_opcode(input logic [6:0] opcode);
    return (opcode[1:0] == 2'b11) &&
           ((opcode[6:2] == OPC_FENCE) || (opcode[6:2] == OPC_SYSTEM));
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC target selection, priority and misalignment detection
//
// Purpose : purely combinational; picks the PC to apply at the end of EXEC.
// Ports   : pc           in  32  current program counter
//           opcode       in   7  instruction[6:0] of the latched instruction
//           branch_taken in   1  take pc+imm
//           pc_select    in   1  take JALR target (overrides branch_taken)
//           imm          in  32  branch/JAL byte offset
//           alu_result   in  32  JALR target before clearing bit 0
//           next_pc      out 32  selected next PC (pc itself for halt opcodes)
//           halt_op      out  1  latched instruction is a halt opcode
//           misaligned   out  1  selected target is not word aligned

import instruction_fetch_pkg::*;

module pc_next_sel (
  input  logic [31:0] pc,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        pc_select,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] next_pc,
  output logic        halt_op,
  output logic        misaligned
);

  always_comb begin
    halt_op = is_halt_opcode(opcode);
    if (halt_op) begin
      next_pc = pc;
    end else if (pc_select) begin
      next_pc = alu_result & ~32'd1;
    end else if (branch_taken) begin
      next_pc = pc + imm;            // wraps modulo 2^32
    end else begin
      next_pc = pc + 32'd4;
    end
    // A frozen PC for a halt opcode is never reported as misaligned.
    misaligned = !halt_op && (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - two-cycle fetch/execute sequencer with halt and misalignment trap
//
// Purpose : fetches one instruction word, presents it for one EXEC cycle, then
//           updates the PC; stops permanently (until rst) on a halt opcode or a
//           misaligned target.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           imem_req/imem_addr       instruction memory read request and address (= pc)
//           imem_ready/imem_rdata    read data valid and word
//           instruction/instr_valid  latched word and its one-cycle commit qualifier
//           pc/pc_plus4              current PC and PC+4
//           branch_taken/pc_select   next-PC controls sampled only in EXEC
//           imm/alu_result           branch offset and JALR target
//           halted/misaligned        sticky status flags

import instruction_fetch_pkg::*;

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic        pc_select,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        halted,
  output logic        misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         halted_q, halted_d;
  logic         misaligned_q, misaligned_d;

  logic [31:0]  sel_next_pc;
  logic         sel_halt_op;
  logic         sel_misaligned;

  pc_next_sel u_pc_next_sel (
    .pc           (pc_q),
    .opcode       (instr_q[6:0]),
    .branch_taken (branch_taken),
    .pc_select    (pc_select),
    .imm          (imm),
    .alu_result   (alu_result),
    .next_pc      (sel_next_pc),
    .halt_op      (sel_halt_op),
    .misaligned   (sel_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (sel_halt_op) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (sel_misaligned) begin
          // PC keeps the address of the offending jump/branch.
          state_d      = ST_HALT;
          halted_d     = 1'b1;
          misaligned_d = 1'b1;
        end else begin
          pc_d    = sel_next_pc;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Decoded straight from the state flop; masked by rst so the request
  // drops immediately when reset is asserted mid-fetch.
  assign imem_req    = (state_q == ST_FETCH) && !rst;
  assign instr_valid = (state_q == ST_EXEC)  && !rst;

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instruction = instr_q;
  assign halted      = halted_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized scoreboard bench for instruction_fetch

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken = 1'b0;
  logic        pc_select = 1'b0;
  logic [31:0] imm = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        halted;
  logic        misaligned;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .pc_select    (pc_select),
    .imm          (imm),
    .alu_result   (alu_result),
    .halted       (halted),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exec_rec_t;

  logic [31:0] fetchq[$];
  exec_rec_t   execq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req) begin
        if (fetchq.size() == 0) fail_event("fetch_unexpected");
        else begin
          check32("imem_addr", imem_addr, fetchq[0]);
          if (imem_ready) void'(fetchq.pop_front());
        end
      end
      if (instr_valid) begin
        if (execq.size() == 0) fail_event("exec_unexpected");
        else begin
          exec_rec_t r;
          r = execq.pop_front();
          check32("exec_pc", pc, r.pc);
          check32("exec_instruction", instruction, r.instr);
          check32("exec_pc_plus4", pc_plus4, r.pc + 32'd4);
          check32("exec_imem_req", {31'b0, imem_req}, 32'd0);
        end
      end
    end
  end

  // Set inputs for the coming cycle, then let that edge happen.
  task automatic drive(input logic r, input logic [31:0] d, input logic bt, input logic ps,
                       input logic [31:0] im, input logic [31:0] al);
    imem_ready = r;  imem_rdata = d;
    branch_taken = bt;  pc_select = ps;  imm = im;  alu_result = al;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input logic r);
    drive(r, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic check_status(input string tag, input logic h, input logic m, input logic [31:0] p);
    check32({tag, "_halted"}, {31'b0, halted}, {31'b0, h});
    check32({tag, "_misaligned"}, {31'b0, misaligned}, {31'b0, m});
    check32({tag, "_pc"}, pc, p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b1;        // must be discarded
    imem_rdata = 32'h0000_0073;
    @(posedge clk);
    #1;
    check_status("reset", 1'b0, 1'b0, 32'h0);
    check32("reset_instruction", instruction, 32'h0000_0013);
    check32("reset_req", {31'b0, imem_req}, 32'd0);
    check32("reset_valid", {31'b0, instr_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 11))
      0: w = 32'h0000_0073;   // ECALL
      1: w = 32'h0010_0073;   // EBREAK
      2: w = 32'h0ff0_000f;   // FENCE
      default: begin
        w = $urandom;
        if (w[6:0] == 7'h73 || w[6:0] == 7'h0f) w[6:0] = 7'h13;
      end
    endcase
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_m, w, im, al, tgt;
    logic        bt, ps, stop, mis_m;
    int          off;

    @(posedge clk);
    #1;
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      pc_m  = 32'h0;
      stop  = 1'b0;
      mis_m = 1'b0;
      for (int k = 0; k < 20 && !stop; k++) begin
        w = (ep == 0) ? 32'h0010_0093 : rand_word();   // first episode: plain ADDI stream
        fetchq.push_back(pc_m);
        for (int s = 0; s < int'($urandom_range(0, 3)); s++) drive_idle(1'b0);
        drive(1'b1, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        execq.push_back('{pc: pc_m, instr: w});

        off = int'($urandom_range(0, 63)) - 32;
        im  = 32'(off * 4);
        if ($urandom_range(0, 15) == 0) im = im | 32'd2;
        case ($urandom_range(0, 7))
          0: al = 32'hFFFF_FFFC;
          1: al = 32'h0000_0102;
          2: al = 32'h0000_0041;
          default: al = $urandom & ~32'd2;
        endcase
        bt = 1'($urandom_range(0, 1));
        ps = ($urandom_range(0, 3) == 0);
        if (ep == 0) begin bt = 1'b0; ps = 1'b0; end

        // Reference: halt opcodes freeze, otherwise JALR > branch > sequential.
        if (w[6:0] == 7'h73 || w[6:0] == 7'h0f) begin
          stop = 1'b1;
        end else begin
          if (ps)      tgt = al & 32'hFFFF_FFFE;
          else if (bt) tgt = pc_m + im;
          else         tgt = pc_m + 32'd4;
          if (tgt % 4 != 0) begin
            stop  = 1'b1;
            mis_m = 1'b1;
          end else begin
            pc_m = tgt;
          end
        end
        drive(1'($urandom_range(0, 1)), $urandom, bt, ps, im, al);
      end
      if (stop) begin
        for (int c = 0; c < 3; c++) begin
          check_status("halt", 1'b1, mis_m, pc_m);
          check32("halt_req", {31'b0, imem_req}, 32'd0);
          check32("halt_valid", {31'b0, instr_valid}, 32'd0);
          drive_idle(1'($urandom_range(0, 1)));
        end
      end
      check32("fetchq_drained", fetchq.size(), 32'd0);
      check32("execq_drained", execq.size(), 32'd0);
      fetchq.delete();
      execq.delete();
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
